// File: rtl/i2c_seq_pkg.sv
// Shared state, status codes, command record and address-byte helpers for the I2C register sequencer.
package i2c_seq_pkg;

  localparam int SEQ_MAX_LEN = 16;
  localparam int SEQ_RETRIES = 3;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ISSUE,
    REG,
    WDATA,
    RD_ADDR,
    RDATA,
    DONE
  } state_e;

  typedef enum logic [2:0] {
    ERR_OK        = 3'd0,
    ERR_ADDR_NACK = 3'd1,
    ERR_DATA_NACK = 3'd2,
    ERR_BUS       = 3'd3,
    ERR_BAD_LEN   = 3'd4
  } err_e;

  typedef struct packed {
    logic       rd;
    logic [6:0] dev;
    logic [7:0] reg_addr;
  } cmd_t;

  function automatic logic [7:0] addr_w(input logic [6:0] dev);
    return {dev, 1'b0};
  endfunction

  function automatic logic [7:0] addr_r(input logic [6:0] dev);
    return {dev, 1'b1};
  endfunction

endpackage

// File: rtl/i2c_seq_buffer.sv
// Byte FIFO holding a command's write payload; count/flush exposed, pop data is the combinational head.
// Zero-latency head, push ignored when full, pop ignored when empty; flush wins over push/pop.
module i2c_seq_buffer #(
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [7:0]       push_dat_i,
  input  logic             pop_i,
  output logic [7:0]       pop_dat_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [7:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_push   = push_i && (cnt_q != CNT_W'(DEPTH));
  assign do_pop    = pop_i && (cnt_q != '0);
  assign pop_dat_o = mem_q[rd_ptr_q];
  assign count_o   = cnt_q;

  always_ff @(posedge clk_in) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_dat_i;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/i2c_reg_sequencer.sv
// Turns one register read/write command into I2C master byte transfers; I2C_SEQ_RETRY_EN enables address-NACK retries.
// Master-side outputs are registered one cycle after each master event; payload fully buffered before START, rd side has no backpressure.
module i2c_reg_sequencer
  import i2c_seq_pkg::*;
#(
  parameter int MAX_LEN = SEQ_MAX_LEN,
  parameter int LEN_W   = $clog2(MAX_LEN + 1),
  parameter int RETRIES = SEQ_RETRIES
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic             cmd_read_i,
  input  logic [6:0]       cmd_dev_addr_i,
  input  logic [7:0]       cmd_reg_addr_i,
  input  logic [LEN_W-1:0] cmd_len_i,
  input  logic             wr_valid_i,
  output logic             wr_ready_o,
  input  logic [7:0]       wr_data_i,
  output logic             rd_valid_o,
  output logic [7:0]       rd_data_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [2:0]       err_o,
  output logic             m_mode_o,
  output logic             m_transfer_start_o,
  output logic             m_transfer_continue_o,
  output logic [7:0]       m_data_tx_o,
  input  logic             m_transfer_ready_i,
  input  logic             m_interrupt_i,
  input  logic             m_transaction_complete_i,
  input  logic             m_nack_i,
  input  logic             m_start_err_i,
  input  logic             m_arbitration_err_i,
  input  logic [7:0]       m_data_rx_i
);

`ifdef I2C_SEQ_RETRY_EN
  localparam bit RETRY_EN = 1'b1;
`else
  localparam bit RETRY_EN = 1'b0;
`endif
  localparam int TRY_W = $clog2(RETRIES + 2);

  state_e           state_q, state_d;
  cmd_t             cmd_q, cmd_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [TRY_W-1:0] tries_q, tries_d;
  logic             start_q, start_d;
  logic             cont_q, cont_d;
  logic             mode_q, mode_d;
  logic [7:0]       tx_q, tx_d;
  logic             rd_vld_q, rd_vld_d;
  logic [7:0]       rd_dat_q, rd_dat_d;
  logic             done_q, done_d;
  err_e             err_q, err_d;
  logic             live_q;

  logic             fin;
  err_e             fin_err;
  logic             bus_bad;
  logic             last_byte;
  logic             fifo_pop;
  logic [7:0]       fifo_dat;
  logic [LEN_W-1:0] fifo_cnt;

  // A NACKed byte may also report incomplete; that case is judged by byte position, not as a bus fault.
  assign bus_bad   = m_start_err_i || m_arbitration_err_i || (!m_transaction_complete_i && !m_nack_i);
  assign last_byte = (len_q == LEN_W'(1));

  i2c_seq_buffer #(
    .DEPTH (MAX_LEN),
    .CNT_W (LEN_W)
  ) u_buf (
    .clk_in     (clk_in),
    .rst_n      (rst_n),
    .flush_i    (state_q == DONE),
    .push_i     (wr_valid_i && wr_ready_o),
    .push_dat_i (wr_data_i),
    .pop_i      (fifo_pop),
    .pop_dat_o  (fifo_dat),
    .count_o    (fifo_cnt)
  );

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    len_d    = len_q;
    tries_d  = tries_q;
    start_d  = start_q;
    cont_d   = cont_q;
    mode_d   = mode_q;
    tx_d     = tx_q;
    rd_vld_d = 1'b0;
    rd_dat_d = rd_dat_q;
    done_d   = 1'b0;
    err_d    = err_q;
    fifo_pop = 1'b0;
    fin      = 1'b0;
    fin_err  = ERR_OK;
    case (state_q)
      IDLE: begin
        if (cmd_valid_i && cmd_ready_o) begin
          cmd_d.rd       = cmd_read_i;
          cmd_d.dev      = cmd_dev_addr_i;
          cmd_d.reg_addr = cmd_reg_addr_i;
          len_d          = cmd_len_i;
          tries_d        = '0;
          err_d          = ERR_OK;
          if ((cmd_read_i && cmd_len_i == '0) || (cmd_len_i > LEN_W'(MAX_LEN))) begin
            fin     = 1'b1;
            fin_err = ERR_BAD_LEN;
          end else if (!cmd_read_i && cmd_len_i != '0) begin
            state_d = LOAD;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      LOAD: begin
        if (fifo_cnt == len_q) state_d = ISSUE;
      end
      ISSUE: begin
        if (!start_q) begin
          if (m_transfer_ready_i) begin
            start_d = 1'b1;
            mode_d  = 1'b0;
            tx_d    = addr_w(cmd_q.dev);
            cont_d  = 1'b1;
          end
        end else if (m_interrupt_i) begin
          start_d = 1'b0;
          if (bus_bad) begin
            fin     = 1'b1;
            fin_err = ERR_BUS;
          end else if (m_nack_i) begin
            // Payload stays in the buffer across retries; START is re-armed once the master is idle again.
            if (RETRY_EN && tries_q < TRY_W'(RETRIES)) begin
              tries_d = tries_q + 1'b1;
              cont_d  = 1'b0;
            end else begin
              fin     = 1'b1;
              fin_err = ERR_ADDR_NACK;
            end
          end else begin
            tx_d    = cmd_q.reg_addr;
            cont_d  = !cmd_q.rd && (len_q != '0);
            state_d = REG;
          end
        end
      end
      REG: begin
        if (m_interrupt_i) begin
          if (bus_bad) begin
            fin     = 1'b1;
            fin_err = ERR_BUS;
          end else if (m_nack_i) begin
            fin     = 1'b1;
            fin_err = ERR_DATA_NACK;
          end else if (cmd_q.rd) begin
            cont_d  = 1'b0;
            state_d = RD_ADDR;
          end else if (len_q == '0) begin
            fin = 1'b1;
          end else begin
            tx_d     = fifo_dat;
            fifo_pop = 1'b1;
            cont_d   = (len_q > LEN_W'(1));
            state_d  = WDATA;
          end
        end
      end
      WDATA: begin
        if (m_interrupt_i) begin
          if (bus_bad) begin
            fin     = 1'b1;
            fin_err = ERR_BUS;
          end else if (last_byte) begin
            fin = 1'b1;
          end else if (m_nack_i) begin
            fin     = 1'b1;
            fin_err = ERR_DATA_NACK;
          end else begin
            len_d    = len_q - LEN_W'(1);
            tx_d     = fifo_dat;
            fifo_pop = 1'b1;
            cont_d   = (len_q > LEN_W'(2));
          end
        end
      end
      RD_ADDR: begin
        if (!start_q) begin
          if (m_transfer_ready_i) begin
            start_d = 1'b1;
            mode_d  = 1'b0;
            tx_d    = addr_r(cmd_q.dev);
            cont_d  = 1'b1;
          end
        end else if (m_interrupt_i) begin
          start_d = 1'b0;
          if (bus_bad) begin
            fin     = 1'b1;
            fin_err = ERR_BUS;
          end else if (m_nack_i) begin
            fin     = 1'b1;
            fin_err = ERR_ADDR_NACK;
          end else begin
            mode_d  = 1'b1;
            cont_d  = (len_q > LEN_W'(1));
            state_d = RDATA;
          end
        end
      end
      RDATA: begin
        if (m_interrupt_i) begin
          if (bus_bad) begin
            fin     = 1'b1;
            fin_err = ERR_BUS;
          end else begin
            rd_vld_d = 1'b1;
            rd_dat_d = m_data_rx_i;
            if (last_byte) begin
              fin = 1'b1;
            end else begin
              len_d  = len_q - LEN_W'(1);
              cont_d = (len_q > LEN_W'(2));
            end
          end
        end
      end
      DONE: begin
        if (m_transfer_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (fin) begin
      state_d = DONE;
      start_d = 1'b0;
      cont_d  = 1'b0;
      mode_d  = 1'b0;
      done_d  = 1'b1;
      err_d   = fin_err;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q    <= '0;
      len_q    <= '0;
      tries_q  <= '0;
      start_q  <= 1'b0;
      cont_q   <= 1'b0;
      mode_q   <= 1'b0;
      tx_q     <= '0;
      rd_vld_q <= 1'b0;
      rd_dat_q <= '0;
      done_q   <= 1'b0;
      err_q    <= ERR_OK;
      live_q   <= 1'b0;
    end else begin
      cmd_q    <= cmd_d;
      len_q    <= len_d;
      tries_q  <= tries_d;
      start_q  <= start_d;
      cont_q   <= cont_d;
      mode_q   <= mode_d;
      tx_q     <= tx_d;
      rd_vld_q <= rd_vld_d;
      rd_dat_q <= rd_dat_d;
      done_q   <= done_d;
      err_q    <= err_d;
      live_q   <= 1'b1;
    end
  end

  always_comb begin
    cmd_ready_o = 1'b0;
    wr_ready_o  = 1'b0;
    busy_o      = 1'b0;
    case (state_q)
      IDLE: cmd_ready_o = live_q;
      LOAD: begin
        wr_ready_o = (fifo_cnt != len_q);
        busy_o     = 1'b1;
      end
      ISSUE, REG, WDATA, RD_ADDR, RDATA: busy_o = 1'b1;
      default: ;
    endcase
  end

  assign rd_valid_o            = rd_vld_q;
  assign rd_data_o             = rd_dat_q;
  assign done_o                = done_q;
  assign err_o                 = err_q;
  assign m_mode_o              = mode_q;
  assign m_transfer_start_o    = start_q;
  assign m_transfer_continue_o = cont_q;
  assign m_data_tx_o           = tx_q;

endmodule
